// File: rtl/cfu_pkg.sv
// Shared definitions for the flow-controlled SIMD MAC CFU.
// Holds the function codes accepted on req_function_id and the error codes
// returned on resp_error_id, plus a helper for the context-select width.
package cfu_pkg;

    typedef enum logic [1:0] {
        CFU_OP_CLEAR = 2'd0,
        CFU_OP_MAC_U = 2'd1,
        CFU_OP_MAC_S = 2'd2,
        CFU_OP_READ  = 2'd3
    } cfu_op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_FUNC  = 2'd1,
        ERR_BAD_STATE = 2'd2
    } cfu_err_e;

    // Context-select width: at least one bit even for a single accumulator.
    function automatic int unsigned state_id_w(input int unsigned n_acc);
        return (n_acc > 1) ? $clog2(n_acc) : 1;
    endfunction

endpackage

// File: rtl/mulacc_simd_flow_cfu_if.sv
// CFU request/response bus.
// master: CPU side (drives req_*, resp_ready; receives req_ready, resp_*).
// slave : CFU side (the mirror image).
interface mulacc_simd_flow_cfu_if #(
    parameter int unsigned FUNC_W      = 3,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned REQ_DATA_W  = 32,
    parameter int unsigned RESP_DATA_W = 32,
    parameter int unsigned ERR_W       = 32,
    parameter int unsigned STATE_W     = 2
);
    logic                    req_valid;
    logic                    req_ready;
    logic [FUNC_W-1:0]       req_function_id;
    logic [STATE_W-1:0]      req_state_id;
    logic [TAG_W-1:0]        req_id;
    logic [2*REQ_DATA_W-1:0] req_data;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [TAG_W-1:0]        resp_id;
    logic [RESP_DATA_W-1:0]  resp_data;
    logic                    resp_ok;
    logic [ERR_W-1:0]        resp_error_id;

    modport master (
        output req_valid, req_function_id, req_state_id, req_id, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_ok, resp_error_id
    );

    modport slave (
        input  req_valid, req_function_id, req_state_id, req_id, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_ok, resp_error_id
    );
endinterface

// File: rtl/mulacc_simd_dot.sv
// SIMD dot-product slice: registers the per-lane products (S0) and presents
// their extended sum combinationally (feeds the S1 accumulator update).
// Ports: clock, reset_n, en (capture), signed_mode, a/b (packed lanes),
//        sum_c (sum of lane products extended to OUT_W).
// OUT_W must exceed 2*ELT_W.
module mulacc_simd_dot #(
    parameter int unsigned ELT_W  = 8,
    parameter int unsigned N_ELTS = 4,
    parameter int unsigned OUT_W  = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    signed_mode,
    input  logic [ELT_W*N_ELTS-1:0] a,
    input  logic [ELT_W*N_ELTS-1:0] b,
    output logic [OUT_W-1:0]        sum_c
);
    localparam int unsigned PROD_W = 2 * ELT_W;

    logic             signed_q, signed_d;
    logic [OUT_W-1:0] lane_ext [N_ELTS];

    always_comb signed_d = en ? signed_mode : signed_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) signed_q <= 1'b0;
        else          signed_q <= signed_d;
    end

    for (genvar g = 0; g < N_ELTS; g++) begin : g_lane
        logic [ELT_W-1:0]  a_e, b_e;
        logic [PROD_W-1:0] a_x, b_x, prod_d, prod_q;

        // Operands pre-extended to the product width so a plain truncated
        // multiply yields the correct signed or unsigned product.
        always_comb begin
            a_e    = a[g*ELT_W +: ELT_W];
            b_e    = b[g*ELT_W +: ELT_W];
            a_x    = {{ELT_W{signed_mode & a_e[ELT_W-1]}}, a_e};
            b_x    = {{ELT_W{signed_mode & b_e[ELT_W-1]}}, b_e};
            prod_d = en ? (a_x * b_x) : prod_q;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) prod_q <= '0;
            else          prod_q <= prod_d;
        end

        assign lane_ext[g] = {{(OUT_W-PROD_W){signed_q & prod_q[PROD_W-1]}}, prod_q};
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < N_ELTS; i++) sum_c = sum_c + lane_ext[i];
    end

endmodule

// File: rtl/mulacc_simd_flow_cfu.sv
// Flow-controlled SIMD multiply-accumulate CFU with N_ACC accumulator contexts.
// Three stages: S0 products + decoded control, S1 accumulator update,
// S2 output register. The whole pipe advances together, stalling only when
// a presented response is not taken.
// Ports: clock, reset_n (async, active-low), clock_en (0 freezes everything),
//        cfu (slave side of the CFU request/response bus).
module mulacc_simd_flow_cfu
    import cfu_pkg::*;
#(
    parameter int unsigned CFU_FUNCTION_ID_W = 3,
    parameter int unsigned CFU_REQ_RESP_ID_W = 6,
    parameter int unsigned CFU_REQ_DATA_W    = 32,
    parameter int unsigned CFU_REQ_ELT_W     = 8,
    parameter int unsigned CFU_RESP_DATA_W   = CFU_REQ_DATA_W,
    parameter int unsigned CFU_ERROR_ID_W    = CFU_RESP_DATA_W,
    parameter int unsigned N_ACC             = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clock_en,
    mulacc_simd_flow_cfu_if.slave cfu
);
    localparam int unsigned N_ELTS     = CFU_REQ_DATA_W / CFU_REQ_ELT_W;
    localparam int unsigned STATE_ID_W = state_id_w(N_ACC);
    localparam int unsigned TAG_W      = CFU_REQ_RESP_ID_W;
    localparam int unsigned DW         = CFU_RESP_DATA_W;

    logic adv_c, accept_c;
    logic [DW-1:0] sum_c;

    // S0 control
    logic                  v0_q, v0_d;
    logic [TAG_W-1:0]      id0_q, id0_d;
    cfu_op_e               op0_q, op0_d;
    cfu_err_e              err0_q, err0_d;
    logic [STATE_ID_W-1:0] st0_q, st0_d;
    // S1 control + post-update result
    logic                  v1_q, v1_d;
    logic [TAG_W-1:0]      id1_q, id1_d;
    cfu_err_e              err1_q, err1_d;
    logic [DW-1:0]         res1_q, res1_d;
    // S2 output register
    logic                      resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0]          resp_id_q, resp_id_d;
    logic [DW-1:0]             resp_data_q, resp_data_d;
    logic                      resp_ok_q, resp_ok_d;
    logic [CFU_ERROR_ID_W-1:0] resp_error_id_q, resp_error_id_d;

    logic [DW-1:0] acc_q [N_ACC];
    logic [DW-1:0] acc_d [N_ACC];

    // Advance unless a held response is being refused; never accept in reset.
    assign adv_c         = clock_en && !(resp_valid_q && !cfu.resp_ready);
    assign cfu.req_ready = adv_c && reset_n;
    assign accept_c      = cfu.req_valid && cfu.req_ready;

    mulacc_simd_dot #(
        .ELT_W  (CFU_REQ_ELT_W),
        .N_ELTS (N_ELTS),
        .OUT_W  (DW)
    ) u_dot (
        .clock       (clock),
        .reset_n     (reset_n),
        .en          (accept_c),
        .signed_mode (cfu.req_function_id == CFU_FUNCTION_ID_W'(CFU_OP_MAC_S)),
        .a           (cfu.req_data[CFU_REQ_DATA_W-1:0]),
        .b           (cfu.req_data[2*CFU_REQ_DATA_W-1:CFU_REQ_DATA_W]),
        .sum_c       (sum_c)
    );

    // Pipeline advance, error decode and accumulator update.
    always_comb begin
        v0_d = v0_q;  id0_d = id0_q;  op0_d = op0_q;  err0_d = err0_q;  st0_d = st0_q;
        v1_d = v1_q;  id1_d = id1_q;  err1_d = err1_q;  res1_d = res1_q;
        resp_valid_d    = resp_valid_q;
        resp_id_d       = resp_id_q;
        resp_data_d     = resp_data_q;
        resp_ok_d       = resp_ok_q;
        resp_error_id_d = resp_error_id_q;
        for (int unsigned i = 0; i < N_ACC; i++) acc_d[i] = acc_q[i];

        if (adv_c) begin
            v0_d  = accept_c;
            id0_d = cfu.req_id;
            op0_d = cfu_op_e'(cfu.req_function_id[1:0]);
            st0_d = cfu.req_state_id;
            if (cfu.req_function_id > CFU_FUNCTION_ID_W'(CFU_OP_READ))
                err0_d = ERR_BAD_FUNC;
            else if (32'(cfu.req_state_id) >= N_ACC)
                err0_d = ERR_BAD_STATE;
            else
                err0_d = ERR_NONE;

            // Bubbles and erroring requests leave every context untouched.
            v1_d   = v0_q;
            id1_d  = id0_q;
            err1_d = err0_q;
            res1_d = '0;
            if (v0_q && (err0_q == ERR_NONE)) begin
                for (int unsigned i = 0; i < N_ACC; i++) begin
                    if (st0_q == STATE_ID_W'(i)) begin
                        case (op0_q)
                            CFU_OP_CLEAR:               acc_d[i] = '0;
                            CFU_OP_MAC_U, CFU_OP_MAC_S: acc_d[i] = acc_q[i] + sum_c;
                            default:                    acc_d[i] = acc_q[i];
                        endcase
                        res1_d = acc_d[i];
                    end
                end
            end

            resp_valid_d    = v1_q;
            resp_id_d       = id1_q;
            resp_data_d     = res1_q;
            resp_ok_d       = (err1_q == ERR_NONE);
            resp_error_id_d = CFU_ERROR_ID_W'(err1_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v0_q <= 1'b0;  id0_q <= '0;  op0_q <= CFU_OP_CLEAR;  err0_q <= ERR_NONE;  st0_q <= '0;
            v1_q <= 1'b0;  id1_q <= '0;  err1_q <= ERR_NONE;  res1_q <= '0;
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_data_q     <= '0;
            resp_ok_q       <= 1'b1;
            resp_error_id_q <= '0;
            for (int unsigned i = 0; i < N_ACC; i++) acc_q[i] <= '0;
        end else begin
            v0_q <= v0_d;  id0_q <= id0_d;  op0_q <= op0_d;  err0_q <= err0_d;  st0_q <= st0_d;
            v1_q <= v1_d;  id1_q <= id1_d;  err1_q <= err1_d;  res1_q <= res1_d;
            resp_valid_q    <= resp_valid_d;
            resp_id_q       <= resp_id_d;
            resp_data_q     <= resp_data_d;
            resp_ok_q       <= resp_ok_d;
            resp_error_id_q <= resp_error_id_d;
            for (int unsigned i = 0; i < N_ACC; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign cfu.resp_valid    = resp_valid_q;
    assign cfu.resp_id       = resp_id_q;
    assign cfu.resp_data     = resp_data_q;
    assign cfu.resp_ok       = resp_ok_q;
    assign cfu.resp_error_id = resp_error_id_q;

endmodule

// File: tb/tb_mulacc_simd_flow_cfu.sv
// Scoreboard bench for mulacc_simd_flow_cfu. Two instances share one request
// stream: dut4 (N_ACC=4) and dut3 (N_ACC=3, exercises the bad-context path).
module tb_mulacc_simd_flow_cfu;

    logic clock;
    logic reset_n;
    logic clock_en;

    mulacc_simd_flow_cfu_if #(.FUNC_W(3), .TAG_W(6), .REQ_DATA_W(32), .RESP_DATA_W(32),
                              .ERR_W(32), .STATE_W(2)) bus ();
    mulacc_simd_flow_cfu_if #(.FUNC_W(3), .TAG_W(6), .REQ_DATA_W(32), .RESP_DATA_W(32),
                              .ERR_W(32), .STATE_W(2)) bus3 ();

    assign bus3.req_valid       = bus.req_valid;
    assign bus3.req_function_id = bus.req_function_id;
    assign bus3.req_state_id    = bus.req_state_id;
    assign bus3.req_id          = bus.req_id;
    assign bus3.req_data        = bus.req_data;
    assign bus3.resp_ready      = bus.resp_ready;

    mulacc_simd_flow_cfu #(.N_ACC(4)) dut4 (
        .clock    (clock),
        .reset_n  (reset_n),
        .clock_en (clock_en),
        .cfu      (bus)
    );

    mulacc_simd_flow_cfu #(.N_ACC(3)) dut3 (
        .clock    (clock),
        .reset_n  (reset_n),
        .clock_en (clock_en),
        .cfu      (bus3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
        logic        ok;
        logic [31:0] err;
    } rsp_t;

    rsp_t        exp4_q[$];
    rsp_t        exp3_q[$];
    rsp_t        got4, want4, got3, want3;
    int          n_vec = 0;
    int          n_err = 0;
    logic [5:0]  tag_ctr = 6'd0;
    logic [31:0] m_acc [2][4];

    localparam logic [2:0] F_CLR  = 3'd0;
    localparam logic [2:0] F_MACU = 3'd1;
    localparam logic [2:0] F_MACS = 3'd2;
    localparam logic [2:0] F_READ = 3'd3;

    function automatic logic [31:0] dot_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ae = a[8*i +: 8];
            logic [7:0] be = b[8*i +: 8];
            int x = sgn ? int'($signed(ae)) : int'(ae);
            int y = sgn ? int'($signed(be)) : int'(be);
            s = s + x * y;
        end
        return 32'(s);
    endfunction

    // Reference behaviour: d=0 models the 4-context unit, d=1 the 3-context one.
    task automatic model(input int d, input logic [2:0] f, input logic [1:0] st,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rd, output logic rok, output logic [31:0] rerr);
        int unsigned nacc = (d == 0) ? 4 : 3;
        rd = 32'd0;
        rok = 1'b0;
        if (f > 3'd3) rerr = 32'd1;
        else if (32'(st) >= nacc) rerr = 32'd2;
        else begin
            rok = 1'b1;
            rerr = 32'd0;
            case (f)
                F_CLR:   m_acc[d][st] = 32'd0;
                F_MACU:  m_acc[d][st] = m_acc[d][st] + dot_ref(a, b, 1'b0);
                F_MACS:  m_acc[d][st] = m_acc[d][st] + dot_ref(a, b, 1'b1);
                default: ;
            endcase
            rd = m_acc[d][st];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Issue one request; dut4 uses the hand value unless use_model is set.
    task automatic send(input logic [2:0] f, input logic [1:0] st, input logic [31:0] a,
                        input logic [31:0] b, input bit use_model, input logic [31:0] xd,
                        input logic xok, input logic [31:0] xerr);
        rsp_t r4, r3;
        logic [31:0] md, me;
        logic mok;
        int n = 0;
        bus.req_valid       = 1'b1;
        bus.req_function_id = f;
        bus.req_state_id    = st;
        bus.req_id          = tag_ctr;
        bus.req_data        = {b, a};
        do begin
            @(negedge clock);
            n++;
        end while (!bus.req_ready && n < 200);
        if (!bus.req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout tag=%0d", tag_ctr);
        end else begin
            model(0, f, st, a, b, md, mok, me);
            r4.tag = tag_ctr;
            r4.data = use_model ? md : xd;
            r4.ok = use_model ? mok : xok;
            r4.err = use_model ? me : xerr;
            exp4_q.push_back(r4);
            model(1, f, st, a, b, md, mok, me);
            r3.tag = tag_ctr;
            r3.data = md;
            r3.ok = mok;
            r3.err = me;
            exp3_q.push_back(r3);
            tag_ctr = tag_ctr + 6'd1;
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp4_q.size() != 0 || exp3_q.size() != 0) && n < 100) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (exp4_q.size() != 0 || exp3_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout left4=%0d left3=%0d", exp4_q.size(), exp3_q.size());
            exp4_q.delete();
            exp3_q.delete();
        end
    endtask

    // Monitors: pop the expected response whenever a handshake is about to occur.
    always @(negedge clock) begin
        if (reset_n && bus.resp_valid && bus.resp_ready) begin
            got4.tag = bus.resp_id;
            got4.data = bus.resp_data;
            got4.ok = bus.resp_ok;
            got4.err = bus.resp_error_id;
            n_vec++;
            if (exp4_q.size() == 0) begin
                n_err++;
                $display("FAIL dut4_resp unexpected tag=%0d", got4.tag);
            end else begin
                want4 = exp4_q.pop_front();
                if (got4 !== want4) begin
                    n_err++;
                    $display("FAIL dut4_resp got tag=%0d data=%h ok=%0b err=%0d want tag=%0d data=%h ok=%0b err=%0d",
                             got4.tag, got4.data, got4.ok, got4.err, want4.tag, want4.data, want4.ok, want4.err);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && bus3.resp_valid && bus3.resp_ready) begin
            got3.tag = bus3.resp_id;
            got3.data = bus3.resp_data;
            got3.ok = bus3.resp_ok;
            got3.err = bus3.resp_error_id;
            n_vec++;
            if (exp3_q.size() == 0) begin
                n_err++;
                $display("FAIL dut3_resp unexpected tag=%0d", got3.tag);
            end else begin
                want3 = exp3_q.pop_front();
                if (got3 !== want3) begin
                    n_err++;
                    $display("FAIL dut3_resp got tag=%0d data=%h ok=%0b err=%0d want tag=%0d data=%h ok=%0b err=%0d",
                             got3.tag, got3.data, got3.ok, got3.err, want3.tag, want3.data, want3.ok, want3.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  k8;
        logic [5:0]  hold_id;
        logic [31:0] hold_data;
        int          n;

        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 4; s++) m_acc[d][s] = 32'd0;
        reset_n             = 1'b1;
        clock_en            = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_function_id = 3'd0;
        bus.req_state_id    = 2'd0;
        bus.req_id          = 6'd0;
        bus.req_data        = 64'd0;
        bus.resp_ready      = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_ok", 32'(bus.resp_ok), 32'd1);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_resp_err", bus.resp_error_id, 32'd0);
        chk("rst3_req_ready", 32'(bus3.req_ready), 32'd0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;

        clock_en = 1'b0;
        #1 chk("cen_req_ready", 32'(bus.req_ready), 32'd0);
        clock_en = 1'b1;
        #1 chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Gauss sum on context 0
        send(F_CLR, 2'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0);
        for (int k = 1; k <= 100; k++) begin
            k8 = 8'(k);
            send(F_MACU, 2'd0, 32'h0101_0101, {4{k8}}, 0, 32'(2 * k * (k + 1)), 1'b1, 32'd0);
        end
        send(F_READ, 2'd0, 32'd0, 32'd0, 0, 32'd20200, 1'b1, 32'd0);

        // Signed versus unsigned lanes
        send(F_CLR, 2'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0);
        send(F_MACS, 2'd0, 32'hFFFF_FFFF, 32'h0202_0202, 0, 32'hFFFF_FFF8, 1'b1, 32'd0);
        send(F_CLR, 2'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0);
        send(F_MACU, 2'd0, 32'hFFFF_FFFF, 32'h0202_0202, 0, 32'd2040, 1'b1, 32'd0);

        // Interleaved contexts 0 and 3
        send(F_CLR, 2'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0);
        send(F_CLR, 2'd3, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            send(F_MACU, 2'd0, 32'h0101_0101, 32'h0101_0101, 0, 32'(4 * i), 1'b1, 32'd0);
            send(F_MACU, 2'd3, 32'h0202_0202, 32'h0202_0202, 0, 32'(16 * i), 1'b1, 32'd0);
        end
        send(F_READ, 2'd0, 32'd0, 32'd0, 0, 32'd40, 1'b1, 32'd0);
        send(F_READ, 2'd3, 32'd0, 32'd0, 0, 32'd160, 1'b1, 32'd0);

        // Error responses; bad function outranks bad context
        send(3'd5, 2'd0, 32'h0101_0101, 32'h0101_0101, 0, 32'd0, 1'b0, 32'd1);
        send(3'd7, 2'd3, 32'h0101_0101, 32'h0101_0101, 0, 32'd0, 1'b0, 32'd1);
        send(F_MACU, 2'd3, 32'h0101_0101, 32'h0101_0101, 0, 32'd164, 1'b1, 32'd0);
        send(F_READ, 2'd0, 32'd0, 32'd0, 0, 32'd40, 1'b1, 32'd0);
        send(F_READ, 2'd3, 32'd0, 32'd0, 0, 32'd164, 1'b1, 32'd0);
        drain();

        // Random traffic with a 5-cycle response stall in the middle
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    int fsel;
                    logic [2:0] f;
                    n = $urandom_range(0, 2);
                    repeat (n) begin
                        @(posedge clock);
                        #1;
                    end
                    fsel = $urandom_range(0, 9);
                    f = (fsel < 4) ? F_MACU : (fsel < 8) ? F_MACS : (fsel == 8) ? F_READ : 3'd6;
                    send(f, 2'($urandom_range(0, 3)), $urandom, $urandom, 1, 32'd0, 1'b0, 32'd0);
                end
            end
            begin
                repeat (6) @(posedge clock);
                #1 bus.resp_ready = 1'b0;
                n = 0;
                do begin
                    @(negedge clock);
                    n++;
                end while (!bus.resp_valid && n < 50);
                chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
                chk("stall_req_ready_first", 32'(bus.req_ready), 32'd0);
                hold_id = bus.resp_id;
                hold_data = bus.resp_data;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clock);
                    chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
                    chk("stall_hold_id", 32'(bus.resp_id), 32'(hold_id));
                    chk("stall_hold_data", bus.resp_data, hold_data);
                end
                @(posedge clock);
                #1 bus.resp_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with three requests in flight
        send(F_MACU, 2'd0, 32'h0101_0101, 32'h0101_0101, 0, 32'd44, 1'b1, 32'd0);
        send(F_MACU, 2'd1, 32'h0101_0101, 32'h0101_0101, 1, 32'd0, 1'b0, 32'd0);
        send(F_MACU, 2'd0, 32'h0101_0101, 32'h0101_0101, 0, 32'd48, 1'b1, 32'd0);
        chk("inflight_resp_valid", 32'(bus.resp_valid), 32'd1);
        #1 reset_n = 1'b0;
        exp4_q.delete();
        exp3_q.delete();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 4; s++) m_acc[d][s] = 32'd0;
        #1;
        chk("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("async_rst3_resp_valid", 32'(bus3.resp_valid), 32'd0);
        chk("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send(F_READ, 2'd0, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0);
        send(F_READ, 2'd1, 32'd0, 32'd0, 0, 32'd0, 1'b1, 32'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
